demux_1x16_deser: RTL and testbench
===================================

# demux_1x16_deser

Serial-to-parallel capture block: the receive-side counterpart of the 16:1 bit-select mux path. It accepts one bit per valid cycle and steers each bit into slot 0..15 of a 16-bit word using an internal 4-bit slot counter. It hands each completed word to downstream logic over a valid/ready handshake. It sits between the serial bit source and the word-level consumer in the wireless datapath.

## Interface
- `MSB_FIRST`, default 0: 0 = first bit of a frame lands in bit 0; 1 = first bit lands in bit 15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `bit_in` input 1: serial data bit.
- `bit_valid` input 1: `bit_in` is accepted in this cycle.
- `frame_start` input 1: resynchronise; forces the slot counter to 0.
- `out_ready` input 1: consumer accepts `word_out` in this cycle.
- `word_out` output 16: completed word, held stable while `word_valid` is 1.
- `word_valid` output 1: `word_out` holds an unconsumed word.
- `slot` output 4: slot index the next accepted bit will occupy.
- `busy` output 1: FSM is in FILL.
- `overrun` output 1: one-cycle pulse when a completed word is dropped.

## Operation
- FSM states and transitions:
  - IDLE: `bit_valid` is ignored unless `frame_start` is 1.
  - IDLE → FILL on `frame_start`.
  - FILL → FILL continuously; it never returns to IDLE on its own.
  - Reset forces IDLE.
- Bit accept: accepted when `bit_valid` is 1 and either state is FILL or `frame_start` is 1.
- Bit placement: an accepted bit is written to shift/assembly register bit `idx`.
  - `idx` = `slot` when `MSB_FIRST`=0.
  - `idx` = 15−`slot` when `MSB_FIRST`=1.
  - All other assembly bits keep their value.
- Slot counter: 4-bit and unsigned; increments by 1 per accepted bit and wraps 15 → 0.
- `frame_start` handling:
  - The slot counter is forced to 0 and the partially assembled word is discarded (assembly register cleared).
  - If `bit_valid` is also 1, that bit is accepted into slot 0 and the counter becomes 1.
- Word completion: accepting a bit at slot 15 completes the word.
  - The assembled value, including that bit, is transferred to the output holding register.
  - Outcome depends on the handshake state:
    - Holding register empty: load the word; `word_valid` becomes 1.
    - Holding register full and `out_ready` is 1 on the same edge: load the new word; `word_valid` stays 1.
    - Holding register full and `out_ready` is 0: drop the new word, keep the old one, pulse `overrun` for one cycle.
- Handshake:
  - A transfer occurs on any edge where `word_valid` and `out_ready` are both 1.
  - `word_valid` falls on the next cycle unless a new word loads on that edge.
  - `word_out` must not change while `word_valid` is 1 and no transfer has occurred.
- `out_ready` while `word_valid` is 0: no effect.
- Reset values: `word_out`=16'h0000, `word_valid`=0, `slot`=0, `busy`=0, `overrun`=0, assembly register=0, state=IDLE.
- Reset mid-frame or mid-handshake: all state is lost immediately, with no pending word or overrun reported.

## Timing
- Word latency: slot-15 bit accepted at edge N → `word_valid`=1 and `word_out` valid after edge N (visible in cycle N+1).
- `slot` and `busy` are registered outputs; they update on the same edge that accepts the bit.
- `overrun` is a registered pulse, high for exactly the cycle after the dropping edge.
- Throughput: one bit per cycle sustained, so one word per 16 cycles. A consumer asserting `out_ready` continuously never causes an overrun.
- There is no combinational path from any input to any output.

## Structure
- Shared package `deser_pkg`:
  - `WORD_W`=16, `SLOT_W`=4.
  - FSM enum `deser_state_t` {IDLE, FILL}.
- Sub-module `demux_1x16_dec`: combinational 4-to-16 one-hot write-enable decoder with an enable input, built as two 1x8 halves selected by `slot[3]`. The top level uses its output to gate per-bit writes into the assembly register.
- The top level holds the FSM, slot counter, assembly register, holding register and handshake logic.

## Test plan
- Reset/basic capture: reset, then `frame_start` with bits of 16'hA5C3 LSB-first (`MSB_FIRST`=0), `out_ready`=1 → `word_out`=16'hA5C3 with `word_valid` high for exactly one cycle, 16 cycles after the first bit.
- MSB-first: `MSB_FIRST`=1, same bit stream → `word_out`=16'hC3A5 (bit-reversed).
- Backpressure/overrun: `out_ready`=0, send two full words 16'h1234 then 16'hFFFF → first word held, `overrun` pulses once on the 32nd bit, `word_out` stays 16'h1234; then `out_ready`=1 → one transfer, `word_valid` falls.
- Simultaneous load and consume: word 1 pending; `out_ready`=1 on the edge that completes word 2 → `word_valid` stays 1, `word_out` becomes word 2, no `overrun`.
- Resync: `frame_start` with `bit_valid` after 7 bits → partial word discarded, `slot`=1, next complete word contains only post-resync bits. `bit_valid` in IDLE without `frame_start` → `slot` stays 0, no `word_valid`.
- Reset mid-frame: `rst_n` low after 9 bits, with a word pending → all outputs return to reset values next cycle, state IDLE.

Source files
------------

// File: rtl/deser_pkg.sv
// +----------------------------------------------------------------------+
// | deser_pkg : shared widths and FSM encoding for the 1x16 deserialiser |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package deser_pkg;

    localparam int WORD_W = 16;
    localparam int SLOT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } deser_state_t;

endpackage : deser_pkg

`default_nettype wire

// File: rtl/demux_1x16_dec.sv
// +----------------------------------------------------------------------+
// | demux_1x16_dec : 4-to-16 one-hot write-enable decoder with enable,   |
// |                  built from two 1x8 halves selected by sel_i[3]      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module demux_1x16_dec
    import deser_pkg::*;
(
    input  logic              en_i,
    input  logic [SLOT_W-1:0] sel_i,
    output logic [WORD_W-1:0] we_o
);

    logic [1:0] half_en;

    assign half_en = {en_i & sel_i[3], en_i & ~sel_i[3]};

    generate
        for (genvar h = 0; h < 2; h++) begin : g_half
            for (genvar b = 0; b < 8; b++) begin : g_bit
                assign we_o[h*8 + b] = half_en[h] && (sel_i[2:0] == 3'(b));
            end
        end
    endgenerate

endmodule : demux_1x16_dec

`default_nettype wire

// File: rtl/demux_1x16_deser.sv
// +----------------------------------------------------------------------+
// | demux_1x16_deser : serial-to-parallel capture into 16-bit words with |
// |                    a valid/ready output holding register            |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module demux_1x16_deser
    import deser_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_start,
    input  logic              out_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              busy,
    output logic              overrun
);

    deser_state_t      state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wvalid_q, wvalid_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic              complete;
    logic [SLOT_W-1:0] slot_eff;
    logic [SLOT_W-1:0] idx;
    logic [WORD_W-1:0] asm_base;
    logic [WORD_W-1:0] we;

    // frame_start restarts the word before the current bit is placed
    assign accept   = bit_valid && ((state_q == FILL) || frame_start);
    assign slot_eff = frame_start ? '0 : slot_q;
    assign asm_base = frame_start ? '0 : asm_q;
    assign idx      = (MSB_FIRST != 0) ? ~slot_eff : slot_eff;
    assign complete = accept && (slot_eff == 4'd15);

    demux_1x16_dec u_dec (
        .en_i  (accept),
        .sel_i (idx),
        .we_o  (we)
    );

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_eff;
        wvalid_d  = wvalid_q;
        word_d    = word_q;
        overrun_d = 1'b0;

        if (frame_start) begin
            state_d = FILL;
        end

        if (accept) begin
            slot_d = slot_eff + 4'd1;
        end

        for (int i = 0; i < WORD_W; i++) begin
            asm_d[i] = we[i] ? bit_in : asm_base[i];
        end

        // A full holding register only accepts a new word if it drains on this edge
        if (complete && (!wvalid_q || out_ready)) begin
            word_d   = asm_d;
            wvalid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (wvalid_q && out_ready) begin
            wvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            asm_q     <= '0;
            word_q    <= '0;
            wvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            asm_q     <= asm_d;
            word_q    <= word_d;
            wvalid_q  <= wvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = wvalid_q;
    assign slot       = slot_q;
    assign busy       = (state_q == FILL);
    assign overrun    = overrun_q;

endmodule : demux_1x16_deser

`default_nettype wire

// File: tb/tb_demux_1x16_deser.sv
// +----------------------------------------------------------------------+
// | tb_demux_1x16_deser : directed self-checking bench for the 1x16      |
// |                       deserialiser (LSB-first and MSB-first builds)  |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_demux_1x16_deser;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        frame_start;
    logic        out_ready;

    logic [15:0] word_out_l, word_out_m;
    logic        word_valid_l, word_valid_m;
    logic [3:0]  slot_l, slot_m;
    logic        busy_l, busy_m;
    logic        overrun_l, overrun_m;

    int tests_run    = 0;
    int tests_failed = 0;

    demux_1x16_deser #(.MSB_FIRST(0)) u_dut_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .out_ready   (out_ready),
        .word_out    (word_out_l),
        .word_valid  (word_valid_l),
        .slot        (slot_l),
        .busy        (busy_l),
        .overrun     (overrun_l)
    );

    demux_1x16_deser #(.MSB_FIRST(1)) u_dut_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .out_ready   (out_ready),
        .word_out    (word_out_m),
        .word_valid  (word_valid_m),
        .slot        (slot_m),
        .busy        (busy_m),
        .overrun     (overrun_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Sends bits [first..15] of data, optionally with frame_start on the first one
    task automatic send_bits(input logic [15:0] data, input int first, input bit fs);
        for (int i = first; i < 16; i++) begin
            bit_in      = data[i];
            bit_valid   = 1'b1;
            frame_start = fs && (i == first);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        tests_run++;
        if ({word_out_l, word_valid_l, slot_l, busy_l, overrun_l} !== 23'h0) begin
            tests_failed++;
            $display("FAIL reset_values: got word=%h v=%b slot=%0d busy=%b ovr=%b, need all zero",
                     word_out_l, word_valid_l, slot_l, busy_l, overrun_l);
        end
    endtask

    task automatic test_basic_capture();
        logic [15:0] d;
        d = 16'hA5C3;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit_in = d[i]; bit_valid = 1'b1; frame_start = (i == 0);
            tick();
            if (i == 14) begin
                tests_run++;
                if (word_valid_l !== 1'b0 || slot_l !== 4'd15 || busy_l !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL basic_pre_complete: got v=%b slot=%0d busy=%b, need v=0 slot=15 busy=1",
                             word_valid_l, slot_l, busy_l);
                end
            end
        end
        idle_inputs();
        tests_run++;
        if (word_valid_l !== 1'b1 || word_out_l !== 16'hA5C3 || slot_l !== 4'd0) begin
            tests_failed++;
            $display("FAIL basic_word: got v=%b word=%h slot=%0d, need v=1 word=a5c3 slot=0",
                     word_valid_l, word_out_l, slot_l);
        end
        tick();
        tests_run++;
        if (word_valid_l !== 1'b0 || overrun_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_one_cycle: got v=%b ovr=%b, need v=0 ovr=0", word_valid_l, overrun_l);
        end
    endtask

    task automatic test_msb_first();
        do_reset();
        out_ready = 1'b1;
        send_bits(16'hA5C3, 0, 1'b1);
        tests_run++;
        if (word_valid_m !== 1'b1 || word_out_m !== 16'hC3A5) begin
            tests_failed++;
            $display("FAIL msb_first_word: got v=%b word=%h, need v=1 word=c3a5", word_valid_m, word_out_m);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready = 1'b0;
        send_bits(16'h1234, 0, 1'b1);
        tests_run++;
        if (word_valid_l !== 1'b1 || word_out_l !== 16'h1234 || overrun_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_first_word: got v=%b word=%h ovr=%b, need v=1 word=1234 ovr=0",
                     word_valid_l, word_out_l, overrun_l);
        end
        send_bits(16'hFFFF, 0, 1'b0);
        tests_run++;
        if (overrun_l !== 1'b1 || word_out_l !== 16'h1234 || word_valid_l !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovr_pulse: got ovr=%b word=%h v=%b, need ovr=1 word=1234 v=1",
                     overrun_l, word_out_l, word_valid_l);
        end
        tick();
        tests_run++;
        if (overrun_l !== 1'b0 || word_out_l !== 16'h1234) begin
            tests_failed++;
            $display("FAIL ovr_single_cycle: got ovr=%b word=%h, need ovr=0 word=1234", overrun_l, word_out_l);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (word_valid_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_drain: got v=%b, need v=0", word_valid_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        d = 16'h5A5A;
        do_reset();
        out_ready = 1'b0;
        send_bits(16'h00FF, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bit_in = d[i]; bit_valid = 1'b1; frame_start = 1'b0;
            out_ready = (i == 15);
            tick();
        end
        idle_inputs();
        tests_run++;
        if (word_valid_l !== 1'b1 || word_out_l !== 16'h5A5A || overrun_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_load_consume: got v=%b word=%h ovr=%b, need v=1 word=5a5a ovr=0",
                     word_valid_l, word_out_l, overrun_l);
        end
        tick();
        tests_run++;
        if (word_valid_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got v=%b, need v=0", word_valid_l);
        end
    endtask

    task automatic test_resync();
        logic [15:0] d;
        d = 16'h3C30;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1; frame_start = (i == 0);
            tick();
        end
        tests_run++;
        if (slot_l !== 4'd7) begin
            tests_failed++;
            $display("FAIL resync_partial_slot: got slot=%0d, need 7", slot_l);
        end
        bit_in = d[0]; bit_valid = 1'b1; frame_start = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (slot_l !== 4'd1 || word_valid_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL resync_slot: got slot=%0d v=%b, need slot=1 v=0", slot_l, word_valid_l);
        end
        send_bits(d, 1, 1'b0);
        tests_run++;
        if (word_valid_l !== 1'b1 || word_out_l !== 16'h3C30) begin
            tests_failed++;
            $display("FAIL resync_word: got v=%b word=%h, need v=1 word=3c30", word_valid_l, word_out_l);
        end
    endtask

    task automatic test_idle_ignore();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_in = i[0]; bit_valid = 1'b1; frame_start = 1'b0;
            tick();
        end
        idle_inputs();
        tests_run++;
        if (slot_l !== 4'd0 || word_valid_l !== 1'b0 || busy_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ignore: got slot=%0d v=%b busy=%b, need slot=0 v=0 busy=0",
                     slot_l, word_valid_l, busy_l);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        d = 16'hFFFF;
        do_reset();
        out_ready = 1'b0;
        send_bits(16'hBEEF, 0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            bit_in = d[i]; bit_valid = 1'b1; frame_start = 1'b0;
            tick();
        end
        tests_run++;
        if (slot_l !== 4'd9 || word_valid_l !== 1'b1 || word_out_l !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL midrst_setup: got slot=%0d v=%b word=%h, need slot=9 v=1 word=beef",
                     slot_l, word_valid_l, word_out_l);
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({word_out_l, word_valid_l, slot_l, busy_l, overrun_l} !== 23'h0) begin
            tests_failed++;
            $display("FAIL midrst_values: got word=%h v=%b slot=%0d busy=%b ovr=%b, need all zero",
                     word_out_l, word_valid_l, slot_l, busy_l, overrun_l);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (slot_l !== 4'd0 || busy_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_idle: got slot=%0d busy=%b, need slot=0 busy=0", slot_l, busy_l);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_capture();
        test_msb_first();
        test_overrun();
        test_back_to_back();
        test_resync();
        test_idle_ignore();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_demux_1x16_deser

`default_nettype wire
